// File: rtl/uart_mmio_if.sv
// Register-access port of the memory-mapped UART: byte address, store data/strobe, read data.
interface uart_mmio_if;
  logic [31:0] uart_addr;
  logic [31:0] uart_write_data;
  logic        uart_wen;
  logic [31:0] uart_read_data;

  modport master (
    output uart_addr,
    output uart_write_data,
    output uart_wen,
    input  uart_read_data
  );

  modport slave (
    input  uart_addr,
    input  uart_write_data,
    input  uart_wen,
    output uart_read_data
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO + transmitter, receiver with one holding register,
// STATUS and BAUDDIV registers, combinational register reads.
module uart_mmio #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic       clk,
  input  logic       rst,
  uart_mmio_if.slave bus,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       uart_irq
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] FULL_CNT = TX_DEPTH[PW:0];

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [1:0] reg_sel;
  logic       wr_tx, wr_rx, wr_stat, wr_baud;
  logic       unused_bus_bits;

  assign reg_sel = bus.uart_addr[3:2];
  assign wr_tx   = bus.uart_wen && (reg_sel == 2'd0);
  assign wr_rx   = bus.uart_wen && (reg_sel == 2'd1);
  assign wr_stat = bus.uart_wen && (reg_sel == 2'd2);
  assign wr_baud = bus.uart_wen && (reg_sel == 2'd3);
  assign unused_bus_bits = ^{bus.uart_addr[31:4], bus.uart_addr[1:0], bus.uart_write_data[31:16]};

  logic [15:0] baud_div;

  always_ff @(posedge clk) begin
    if (rst)          baud_div <= DEFAULT_DIV;
    else if (wr_baud) baud_div <= bus.uart_write_data[15:0];
  end

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, fifo_push, tx_pop, tx_drop_set;

  assign fifo_full   = (fifo_cnt == FULL_CNT);
  assign fifo_empty  = (fifo_cnt == '0);
  // A full FIFO still accepts a store when the transmitter pops in the same cycle
  assign fifo_push   = wr_tx && (!fifo_full || tx_pop);
  assign tx_drop_set = wr_tx && fifo_full && !tx_pop;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= bus.uart_write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  tx_state_t   tx_state, tx_state_nxt;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        txd_q, tx_tick, tx_busy;

  assign tx_tick  = (tx_cnt == 16'd0);
  assign tx_busy  = (tx_state != TX_IDLE);
  assign uart_txd = txd_q;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) begin
                  tx_pop       = 1'b1;
                  tx_state_nxt = TX_START;
                end
      TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_tick) begin
                  // Back-to-back frames: the next start bit follows the stop bit directly
                  if (!fifo_empty) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = TX_START;
                  end else begin
                    tx_state_nxt = TX_IDLE;
                  end
                end
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txd_q    <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_pop) begin
        tx_shift <= fifo_mem[rd_ptr];
        txd_q    <= 1'b0;
        tx_cnt   <= baud_div;
      end else if (tx_busy) begin
        if (tx_tick) begin
          tx_cnt <= baud_div;
          case (tx_state)
            TX_START: begin
              txd_q    <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= 3'd0;
            end
            TX_DATA: begin
              if (tx_bit == 3'd7) begin
                txd_q <= 1'b1;
              end else begin
                txd_q    <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_bit   <= tx_bit + 3'd1;
              end
            end
            default: txd_q <= 1'b1;
          endcase
        end else begin
          tx_cnt <= tx_cnt - 16'd1;
        end
      end
    end
  end

  // Receive: two-stage synchronizer, then a third stage for falling-edge detection
  logic        rxd_p0, rxd_p1, rxd_p2;
  logic        rx_fall, rx_tick, rx_stop_evt;
  logic [16:0] div_plus1;
  logic [15:0] rx_half;
  rx_state_t   rx_state, rx_state_nxt;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign rx_fall     = rxd_p2 && !rxd_p1;
  assign rx_tick     = (rx_cnt == 16'd0);
  assign div_plus1   = {1'b0, baud_div} + 17'd1;
  assign rx_half     = div_plus1[16:1];
  assign rx_stop_evt = (rx_state == RX_STOP) && rx_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
      RX_START: if (rx_tick) rx_state_nxt = rxd_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == RX_IDLE) begin
        if (rx_fall) rx_cnt <= rx_half;
      end else if (rx_tick) begin
        rx_cnt <= baud_div;
        if (rx_state == RX_START) rx_bit <= 3'd0;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rxd_p1, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
      end else begin
        rx_cnt <= rx_cnt - 16'd1;
      end
    end
  end

  logic       rx_valid, rx_overrun, rx_frame_err, tx_drop;
  logic [7:0] rx_byte;
  logic       rx_load, ovr_set, ferr_set;

  // A pop in the same cycle as a completed byte frees the holding register first
  assign rx_load  = rx_stop_evt && rxd_p1 && (!rx_valid || wr_rx);
  assign ovr_set  = rx_stop_evt && rxd_p1 && rx_valid && !wr_rx;
  assign ferr_set = rx_stop_evt && !rxd_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid     <= 1'b0;
      rx_byte      <= 8'd0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      if (rx_load) begin
        rx_valid <= 1'b1;
        rx_byte  <= rx_shift;
      end else if (wr_rx) begin
        rx_valid <= 1'b0;
      end
      if (ovr_set)                                       rx_overrun   <= 1'b1;
      else if (wr_stat && bus.uart_write_data[3])        rx_overrun   <= 1'b0;
      if (ferr_set)                                      rx_frame_err <= 1'b1;
      else if (wr_stat && bus.uart_write_data[5])        rx_frame_err <= 1'b0;
      if (tx_drop_set)                                   tx_drop      <= 1'b1;
      else if (wr_stat && bus.uart_write_data[6])        tx_drop      <= 1'b0;
    end
  end

  assign uart_irq = rx_valid;

  always_comb begin
    bus.uart_read_data = 32'd0;
    case (reg_sel)
      2'd1:    bus.uart_read_data = {rx_valid, 23'd0, rx_byte};
      2'd2:    bus.uart_read_data = {25'd0, tx_drop, rx_frame_err, tx_busy,
                                     rx_overrun, rx_valid, fifo_empty, fifo_full};
      2'd3:    bus.uart_read_data = {16'd0, baud_div};
      default: bus.uart_read_data = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Randomized self-checking bench for uart_mmio against a register/frame-level reference model.
module tb_uart_mmio;
  logic clk = 1'b0;
  logic rst;
  logic uart_txd, uart_rxd, uart_irq;

  uart_mmio_if bus ();

  uart_mmio #(.TX_DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd),
    .uart_irq (uart_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model of the receive side and sticky flags
  logic       m_rx_valid, m_ovr, m_ferr, m_drop;
  logic [7:0] m_rx_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_status(input logic full, input logic empty, input logic busy);
    return {25'd0, m_drop, m_ferr, busy, m_ovr, m_rx_valid, empty, full};
  endfunction

  task automatic model_reset();
    m_rx_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0; m_rx_byte = 8'd0;
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (!stop)          m_ferr = 1'b1;
    else if (m_rx_valid) m_ovr = 1'b1;
    else begin
      m_rx_byte  = b;
      m_rx_valid = 1'b1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.uart_addr       = addr;
    bus.uart_write_data = data;
    bus.uart_wen        = 1'b1;
    @(negedge clk);
    bus.uart_wen        = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.uart_addr = addr;
    #1;
    data = bus.uart_read_data;
  endtask

  // Wait for a start bit, then sample each bit at its centre; frame[0]=start, frame[9]=stop
  task automatic tx_capture(input int bitlen, input int budget, output logic [9:0] frame,
                            output int start_cyc, output logic ok);
    ok = 1'b0;
    frame = '1;
    start_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      start_cyc = cyc;
      for (int k = 1; k < 10 * bitlen; k++) begin
        @(negedge clk);
        if (k % bitlen == bitlen / 2) frame[k / bitlen] = uart_txd;
      end
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int bitlen);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rxd = fr[k];
      repeat (bitlen) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (3 * bitlen) @(negedge clk);
  endtask

  task automatic rx_check(input string tag);
    logic [31:0] rd;
    bus_read(32'h2000_0008, rd);
    chk({tag, "_status"}, rd, exp_status(1'b0, 1'b1, 1'b0));
    bus_read(32'h2000_0004, rd);
    chk({tag, "_rxdata"}, rd, {m_rx_valid, 23'd0, m_rx_byte});
    chk({tag, "_irq"}, {31'd0, uart_irq}, {31'd0, m_rx_valid});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the end, n_pass=%0d", n_pass);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  fr, exp_fr;
    logic [7:0]  txb [10];
    logic [7:0]  b, b2;
    logic        ok, st;
    int          scyc, prev_scyc, div;

    rst = 1'b1;
    uart_rxd = 1'b1;
    bus.uart_addr = 32'h2000_0000;
    bus.uart_write_data = 32'd0;
    bus.uart_wen = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    bus_read(32'h2000_0008, rd); chk("reset_status", rd, 32'h0000_0002);
    bus_read(32'h2000_000C, rd); chk("reset_baud", rd, 32'd433);
    bus_read(32'h2000_0004, rd); chk("reset_rxdata", rd, 32'd0);
    bus_read(32'h2000_0000, rd); chk("txdata_reads0", rd, 32'd0);
    chk("reset_txd", {31'd0, uart_txd}, 32'd1);
    chk("reset_irq", {31'd0, uart_irq}, 32'd0);
    @(negedge clk);

    // Single frame 0xA5, 4 cycles/bit, checked on every cycle
    bus_write(32'h2000_000C, 32'd3);
    bus_write(32'h2000_0000, 32'hA5);
    chk("a5_txd_at_write", {31'd0, uart_txd}, 32'd1);
    exp_fr = {1'b1, 8'hA5, 1'b0};
    for (int off = 0; off < 40; off++) begin
      @(negedge clk);
      chk($sformatf("a5_bit%0d_cyc%0d", off / 4, off % 4), {31'd0, uart_txd}, {31'd0, exp_fr[off / 4]});
      if (off == 39) begin
        bus_read(32'h2000_0008, rd);
        chk("a5_busy_last", rd, exp_status(1'b0, 1'b1, 1'b1));
      end
    end
    @(negedge clk);
    bus_read(32'h2000_0008, rd); chk("a5_idle_status", rd, 32'h0000_0002);
    chk("a5_idle_txd", {31'd0, uart_txd}, 32'd1);

    // Random single frames at random bit lengths
    for (int i = 0; i < 3; i++) begin
      div = $urandom_range(1, 6);
      b = 8'($urandom);
      bus_write(32'h2000_000C, div);
      bus_write(32'h2000_0000, {24'd0, b});
      tx_capture(div + 1, 8, fr, scyc, ok);
      chk("rtx_start_seen", {31'd0, ok}, 32'd1);
      chk("rtx_frame", {22'd0, fr}, {22'd0, 1'b1, b, 1'b0});
      repeat (3) @(negedge clk);
    end

    // Ten back-to-back pushes: nine accepted, the tenth dropped, nine frames with no gap
    bus_write(32'h2000_000C, 32'd3);
    for (int i = 0; i < 10; i++) txb[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(32'h2000_0000, {24'd0, txb[i]});
        m_drop = 1'b1;
        bus_read(32'h2000_0008, rd);
        chk("burst_full_drop", rd, exp_status(1'b1, 1'b0, 1'b1));
      end
      begin
        prev_scyc = 0;
        for (int i = 0; i < 9; i++) begin
          tx_capture(4, 60, fr, scyc, ok);
          chk($sformatf("burst_start%0d", i), {31'd0, ok}, 32'd1);
          chk($sformatf("burst_frame%0d", i), {22'd0, fr}, {22'd0, 1'b1, txb[i], 1'b0});
          if (i > 0) chk($sformatf("burst_gap%0d", i), scyc - prev_scyc, 32'd40);
          prev_scyc = scyc;
        end
      end
    join
    repeat (2) @(negedge clk);
    bus_read(32'h2000_0008, rd); chk("burst_done_status", rd, exp_status(1'b0, 1'b1, 1'b0));
    bus_write(32'h2000_0008, 32'h40);
    m_drop = 1'b0;
    bus_read(32'h2000_0008, rd); chk("drop_cleared", rd, exp_status(1'b0, 1'b1, 1'b0));

    // Receive 0x3C, pop it
    rx_send(8'h3C, 1'b1, 4);
    model_rx(8'h3C, 1'b1);
    bus_read(32'h2000_0004, rd); chk("rx3c_rxdata", rd, 32'h8000_003C);
    rx_check("rx3c");
    bus_write(32'h2000_0004, 32'd0);
    m_rx_valid = 1'b0;
    rx_check("rx3c_pop");

    // Two frames without popping: overrun, first byte kept
    b = 8'($urandom); b2 = 8'($urandom);
    rx_send(b, 1'b1, 4);  model_rx(b, 1'b1);
    rx_send(b2, 1'b1, 4); model_rx(b2, 1'b1);
    rx_check("ovr");
    bus_write(32'h2000_0008, 32'h8);
    m_ovr = 1'b0;
    rx_check("ovr_clr");
    bus_write(32'h2000_0004, 32'd0);
    m_rx_valid = 1'b0;

    // One-cycle glitch must not start a frame
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    rx_check("glitch");

    // Stop bit low: framing error, byte discarded
    b = 8'($urandom);
    rx_send(b, 1'b0, 4); model_rx(b, 1'b0);
    rx_check("ferr");
    bus_write(32'h2000_0008, 32'h20);
    m_ferr = 1'b0;
    rx_check("ferr_clr");

    // Random receive traffic at random baud divisors
    for (int i = 0; i < 8; i++) begin
      div = $urandom_range(2, 9);
      bus_write(32'h2000_000C, div);
      bus_read(32'h2000_000C, rd); chk("rnd_baud", rd, div);
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      rx_send(b, st, div + 1);
      model_rx(b, st);
      rx_check($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        bus_write(32'h2000_0004, 32'd0);
        m_rx_valid = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        bus_write(32'h2000_0008, 32'h28);
        m_ovr = 1'b0; m_ferr = 1'b0;
      end
    end
    rx_check("rnd_end");

    // Reset in the middle of a transmit with bytes still queued
    bus_write(32'h2000_000C, 32'd3);
    bus_write(32'h2000_0000, 32'h55);
    bus_write(32'h2000_0000, 32'h0F);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_mid_txd", {31'd0, uart_txd}, 32'd1);
    bus_read(32'h2000_0008, rd); chk("rst_mid_status", rd, 32'h0000_0002);
    bus_read(32'h2000_000C, rd); chk("rst_mid_baud", rd, 32'd433);
    rx_check("rst_mid");
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) ok = 1'b0;
    end
    chk("rst_mid_txd_stays_idle", {31'd0, ok}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
